debounce_multi: RTL and testbench

Multi-channel debouncer for buttons, switches and other slow mechanical inputs. Each channel has a 2-FF synchroniser, a saturating stability counter, a debounced level and one-cycle edge pulses. Level changes are merged into one ordered event stream with a valid/ready handshake and a small FIFO, so a CPU or UART bridge can consume them without polling every channel.

---
 rtl/debounce_multi_pkg.sv | 26 ++
 rtl/debounce_chan.sv | 98 +++++++++
 rtl/debounce_multi.sv | 159 +++++++++++++++
 tb/tb_debounce_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi_pkg
// Purpose  : Shared event type and width helpers for debounce_multi.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_multi_pkg;

    // Widest channel index an event can carry; the top uses the low bits.
    localparam int c_EV_CHAN_W = 16;

    typedef struct packed {
        logic [c_EV_CHAN_W-1:0] chan;
        logic                   level;
    } ev_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : debounce_chan
// Purpose  : One debounce channel: 2-FF synchroniser, saturating stability
//            counter, debounced level, rise/fall pulses and, when
//            DEBOUNCE_MULTI_HOLD_EN is defined, a long-press hold pulse.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_chan
    import debounce_multi_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int HOLD_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic level,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic update
`ifdef DEBOUNCE_MULTI_HOLD_EN
    ,
    output logic hold
`endif
);

    logic            r_s0;
    logic            r_s1;
    logic [BITS-1:0] r_cnt;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic            w_stable;
    logic            w_update;

    assign w_stable = &r_cnt;
    assign w_update = w_stable && (r_s1 != r_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s0 <= sig_in;
            r_s1 <= r_s0;
            if (r_s0 != r_s1) begin
                r_cnt <= '0;
            end else if (!w_stable) begin
                r_cnt <= r_cnt + BITS'(1);
            end
            r_rise <= w_update && r_s1;
            r_fall <= w_update && !r_s1;
            if (w_update) begin
                r_level <= r_s1;
            end
        end
    end

    assign level  = r_level;
    assign stable = w_stable;
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign update = w_update;

`ifdef DEBOUNCE_MULTI_HOLD_EN
    logic [HOLD_BITS-1:0] r_hcnt;
    logic                 r_hold;

    // Pulse on the edge where the counter lands on all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_hold <= 1'b0;
        end else if (!r_level || w_update) begin
            r_hcnt <= '0;
            r_hold <= 1'b0;
        end else if (!(&r_hcnt)) begin
            r_hcnt <= r_hcnt + HOLD_BITS'(1);
            r_hold <= (r_hcnt == {{(HOLD_BITS-1){1'b1}}, 1'b0});
        end else begin
            r_hold <= 1'b0;
        end
    end

    assign hold = r_hold;
`else
    logic [HOLD_BITS-1:0] w_unused_hold;
    assign w_unused_hold = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : Multi-channel debouncer merging level changes into an ordered
//            valid/ready event stream. Define DEBOUNCE_MULTI_HOLD_EN to add
//            per-channel long-press hold pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int  CHANNELS  = 8,
    parameter int  BITS      = 8,
    parameter int  DEPTH     = 4,
    parameter int  HOLD_BITS = 16,
    localparam int c_CW      = chan_w(CHANNELS),
    localparam int c_OW      = occ_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] stable,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [c_CW-1:0]     ev_chan,
    output logic                ev_level,
    output logic [c_OW-1:0]     ev_count,
    output logic                lost,
    input  logic                lost_clr
`ifdef DEBOUNCE_MULTI_HOLD_EN
    ,
    output logic [CHANNELS-1:0] hold
`endif
);

    localparam int c_PW = $clog2(DEPTH);

    logic [CHANNELS-1:0] w_update;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] w_pick;
    logic [CHANNELS-1:0] w_clr;
    logic [c_CW-1:0]     w_arb_idx;
    logic                w_any;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_valid;
    logic                w_coalesce;
    ev_t                 w_push_ev;
    ev_t                 w_head;
    logic                w_unused_head;
    logic                r_lost;

    ev_t                 r_mem [DEPTH];
    logic [c_PW-1:0]     r_wr;
    logic [c_PW-1:0]     r_rd;
    logic [c_OW-1:0]     r_cnt;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        debounce_chan #(
            .BITS      (BITS),
            .HOLD_BITS (HOLD_BITS)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .sig_in (sig_in[gi]),
            .level  (level[gi]),
            .stable (stable[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi]),
            .update (w_update[gi])
`ifdef DEBOUNCE_MULTI_HOLD_EN
            ,
            .hold   (hold[gi])
`endif
        );
    end

    // Fixed priority: lowest pending channel index wins.
    always_comb begin
        logic w_found;
        w_found   = 1'b0;
        w_pick    = '0;
        w_arb_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_pend[i] && !w_found) begin
                w_found   = 1'b1;
                w_pick[i] = 1'b1;
                w_arb_idx = c_CW'(i);
            end
        end
        w_any = w_found;
    end

    assign w_full  = (r_cnt == c_OW'(DEPTH));
    assign w_valid = (r_cnt != '0);
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_push  = w_any && !w_full;
    assign w_pop   = w_valid && ev_ready;
    assign w_clr   = w_push ? w_pick : '0;

    assign w_coalesce = |(w_update & r_pend & ~w_clr);

    always_comb begin
        w_push_ev       = '0;
        w_push_ev.chan  = c_EV_CHAN_W'(w_arb_idx);
        w_push_ev.level = |(w_pick & level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_lost <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_update;
            if (w_coalesce) begin
                r_lost <= 1'b1;
            end else if (lost_clr) begin
                r_lost <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PW'(1);
            end
            r_cnt <= r_cnt + c_OW'(w_push) - c_OW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_push_ev;
        end
    end

    assign w_head        = r_mem[r_rd];
    assign w_unused_head = ^w_head;

    assign ev_valid = w_valid;
    assign ev_chan  = w_valid ? w_head.chan[c_CW-1:0] : '0;
    assign ev_level = w_valid && w_head.level;
    assign ev_count = r_cnt;
    assign lost     = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Scoreboard bench for debounce_multi (CHANNELS=4, BITS=3, DEPTH=4)
//            against a sample-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int CH    = 4;
    localparam int BITS  = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int OW    = 3;
    // A level commits once this many consecutive samples agree (2^BITS).
    localparam int WIN   = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [CH-1:0] sig_in   = '0;
    logic          ev_ready = 1'b0;
    logic          lost_clr = 1'b0;
    logic [CH-1:0] level, stable, rise, fall;
    logic          ev_valid, ev_level, lost;
    logic [CW-1:0] ev_chan;
    logic [OW-1:0] ev_count;
`ifdef DEBOUNCE_MULTI_HOLD_EN
    logic [CH-1:0] hold;
`endif

    debounce_multi #(
        .CHANNELS  (CH),
        .BITS      (BITS),
        .DEPTH     (DEPTH),
        .HOLD_BITS (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .level    (level),
        .stable   (stable),
        .rise     (rise),
        .fall     (fall),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_chan  (ev_chan),
        .ev_level (ev_level),
        .ev_count (ev_count),
        .lost     (lost),
        .lost_clr (lost_clr)
`ifdef DEBOUNCE_MULTI_HOLD_EN
        ,
        .hold     (hold)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int chan; int lvl; } exp_ev_t;
    exp_ev_t sb_q[$];

    // Reference model state (as after the most recent clock edge)
    bit          m_armed = 1'b0;
    bit [CH-1:0] m_level, m_stable, m_rise, m_fall, m_pend;
    int          m_cnt;
    bit          m_lost;
    int          m_edges;
    bit          hist [CH][WIN+2];   // [WIN+1] is the newest raw sample

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        m_cnt = 0; m_lost = 1'b0; m_edges = 0;
        for (int i = 0; i < CH; i++)
            for (int j = 0; j < WIN + 2; j++) hist[i][j] = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step();
        bit [CH-1:0] chg, clr, nl;
        bit          pop, same;
        int          idx;
        // hist[WIN] is the synchronised value the DUT compares on this edge
        for (int i = 0; i < CH; i++) chg[i] = m_stable[i] && (hist[i][WIN] != m_level[i]);
        pop = (m_cnt > 0) && ev_ready;
        clr = '0;
        idx = -1;
        for (int i = CH - 1; i >= 0; i--) if (m_pend[i]) idx = i;
        if (idx >= 0 && m_cnt < DEPTH) begin
            clr[idx] = 1'b1;
            sb_q.push_back('{idx, int'(m_level[idx])});
        end
        if ((chg & m_pend & ~clr) != '0) m_lost = 1'b1;
        else if (lost_clr)              m_lost = 1'b0;
        m_cnt  = m_cnt + ((clr != '0) ? 1 : 0) - (pop ? 1 : 0);
        m_pend = (m_pend & ~clr) | chg;
        nl      = m_level ^ chg;
        m_rise  = chg & nl;
        m_fall  = chg & ~nl;
        m_level = nl;
        m_edges++;
        for (int i = 0; i < CH; i++) begin
            for (int j = 0; j < WIN + 1; j++) hist[i][j] = hist[i][j+1];
            hist[i][WIN+1] = sig_in[i];
            same = 1'b1;
            for (int j = 2; j <= WIN; j++) if (hist[i][j] != hist[i][1]) same = 1'b0;
            m_stable[i] = same && (m_edges >= WIN - 1);
        end
    endtask

    // Compare registered outputs with the model, then advance it one edge.
    always @(negedge clk) begin
        if (m_armed) begin
            check("level",    level,    m_level);
            check("stable",   stable,   m_stable);
            check("rise",     rise,     m_rise);
            check("fall",     fall,     m_fall);
            check("ev_valid", ev_valid, m_cnt != 0);
            check("ev_count", ev_count, m_cnt);
            check("lost",     lost,     m_lost);
        end
        if (rst) begin
            model_reset();
            m_armed = 1'b1;
        end else if (m_armed) begin
            model_step();
        end
    end

    // Event monitor: head must match the oldest expected event.
    always @(negedge clk) begin
        if (m_armed && !rst && ev_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ev_unexpected: got chan %0d level %0d, expected none at %0t",
                         ev_chan, ev_level, $time);
            end else begin
                check("ev_chan",  ev_chan,  sb_q[0].chan);
                check("ev_level", ev_level, sb_q[0].lvl);
                if (ev_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        ev_ready = 1'b1;
        // clean step on ch2
        sig_in[2] = 1'b1;           cyc(20);
        // short glitch on ch0
        sig_in[0] = 1'b1;           cyc(5);
        sig_in[0] = 1'b0;           cyc(20);
        // ch1 and ch3 settle together
        ev_ready = 1'b0;
        sig_in[1] = 1'b1; sig_in[3] = 1'b1;
        cyc(16);
        ev_ready = 1'b1;            cyc(6);
        // backpressure: four changes fill the FIFO, two more wait pending
        ev_ready = 1'b0;
        sig_in = ~sig_in;           cyc(14);
        sig_in[0] = ~sig_in[0]; sig_in[2] = ~sig_in[2];
        cyc(14);
        ev_ready = 1'b1;            cyc(12);
        // coalescing: full FIFO, ch0 toggles twice
        ev_ready = 1'b0;
        sig_in = ~sig_in;           cyc(14);
        sig_in[0] = ~sig_in[0];     cyc(14);
        sig_in[0] = ~sig_in[0];     cyc(14);
        lost_clr = 1'b1;            cyc(1);
        lost_clr = 1'b0;            cyc(2);
        ev_ready = 1'b1;            cyc(12);
        // reset with events queued
        ev_ready = 1'b0;
        sig_in[1] = ~sig_in[1]; sig_in[2] = ~sig_in[2];
        cyc(14);
        sig_in[3] = ~sig_in[3];     cyc(10);
        rst = 1'b1;                 cyc(1);
        rst = 1'b0; ev_ready = 1'b1;
        cyc(20);
        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 19) == 0) sig_in[i] = ~sig_in[i];
            if ($urandom_range(0, 7) == 0) ev_ready = ~ev_ready;
            lost_clr = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 1999) == 0);
            cyc(1);
        end
        // drain
        rst = 1'b0; lost_clr = 1'b0; ev_ready = 1'b1;
        cyc(20);
        for (int t = 0; t < 200 && (sb_q.size() != 0 || m_pend != '0); t++) cyc(1);
        cyc(2);
        check("drain_empty", sb_q.size(), 0);
        check("drain_count", ev_count, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
